// File: rtl/lp_sqrt_result_buffer_if.sv
// Result hand-off stream from the sqrt result buffer to the next stage.
// Latency: wires only, no storage.
// Backpressure: out_ready from the consumer holds the head entry in place.
interface lp_sqrt_result_buffer_if #(
    parameter int root_width = 4,
    parameter int id_width   = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [root_width-1:0] out_root;
    logic [id_width-1:0]   out_id;

    // Buffer side: presents the head entry and watches ready.
    modport master (
        output out_valid,
        output out_root,
        output out_id,
        input  out_ready
    );

    // Consumer side: samples the head entry and drives ready.
    modport slave (
        input  out_valid,
        input  out_root,
        input  out_id,
        output out_ready
    );
endinterface

// File: rtl/lp_sqrt_result_buffer.sv
// Captures sqrt results into a first-word-fall-through FIFO and checks ID sequence.
// Latency: 1 cycle from accepted arrive to out_valid when empty; no bypass path.
// Backpressure: accept_n=1 when full (registered decode); out_ready=0 holds the head.
module lp_sqrt_result_buffer #(
    parameter int width       = 8,
    parameter int id_width    = 8,
    parameter int depth       = 4,
    parameter int check_order = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         arrive,
    input  logic [(width+1)/2-1:0]       root,
    input  logic [id_width-1:0]          arrive_id,
    output logic                         accept_n,
    lp_sqrt_result_buffer_if.master      out_if,
    output logic [$clog2(depth):0]       count,
    output logic                         id_err,
    input  logic                         clr_err
);
    localparam int RW = (width + 1) / 2;
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    // One stored result: the root and the ID it arrived with.
    typedef struct packed {
        logic [RW-1:0]       root;
        logic [id_width-1:0] id;
    } entry_t;

    entry_t        mem [depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    entry_t        hold_q;
    entry_t        head;
    logic          push;
    logic          pop;
    logic          not_empty;
    logic          full;

    // Flow decode is taken from the registered occupancy only, so accept_n
    // never depends combinationally on arrive or out_ready.
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(depth));
    assign push      = arrive & ~full;
    assign pop       = not_empty & out_if.out_ready;

    // Store the accepted result at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= '{root: root, id: arrive_id};
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Remember the head while one exists so an emptied FIFO keeps showing
    // the last result instead of whatever stale slot rd_ptr now points at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (not_empty) begin
            hold_q <= mem[rd_ptr];
        end
    end

    // Head selection: live entry when occupied, held value otherwise.
    always_comb begin
        head = hold_q;
        if (not_empty) begin
            head = mem[rd_ptr];
        end
    end

    assign accept_n         = full;
    assign count            = count_q;
    assign out_if.out_valid = not_empty;
    assign out_if.out_root  = head.root;
    assign out_if.out_id    = head.id;

    generate
        if (check_order != 0) begin : g_order
            logic [id_width-1:0] exp_id;
            logic                err_q;

            // Sticky sequence error; a setting push beats clr_err, and the
            // expected ID follows the last pushed ID so the check resyncs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    exp_id <= '0;
                    err_q  <= 1'b0;
                end else begin
                    if (push && (arrive_id != exp_id)) begin
                        err_q <= 1'b1;
                    end else if (clr_err) begin
                        err_q <= 1'b0;
                    end
                    if (push) begin
                        exp_id <= arrive_id + id_width'(1);
                    end
                end
            end

            assign id_err = err_q;
        end else begin : g_no_order
            assign id_err = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_lp_sqrt_result_buffer.sv
module tb_lp_sqrt_result_buffer;
    localparam int WIDTH = 8;
    localparam int IDW   = 8;
    localparam int DEPTH = 4;
    localparam int RW    = (WIDTH + 1) / 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arrive = 1'b0;
    logic [RW-1:0]  root = '0;
    logic [IDW-1:0] arrive_id = '0;
    logic           accept_n;
    logic [2:0]     count;
    logic           id_err;
    logic           clr_err = 1'b0;

    lp_sqrt_result_buffer_if #(.root_width(RW), .id_width(IDW)) out_if ();

    lp_sqrt_result_buffer #(
        .width(WIDTH), .id_width(IDW), .depth(DEPTH), .check_order(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arrive(arrive), .root(root),
        .arrive_id(arrive_id), .accept_n(accept_n), .out_if(out_if),
        .count(count), .id_err(id_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard of expected FIFO contents, {root, id}, plus ID-check model.
    logic [RW+IDW-1:0] sb[$];
    logic [RW+IDW-1:0] last_out = '0;
    logic [IDW-1:0]    m_exp = '0;
    logic              m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        last_out = '0;
        m_exp    = '0;
        m_err    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arrive = 1'b0; out_if.out_ready = 1'b0; clr_err = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: check DUT state against the model at the falling edge,
    // then drive this cycle's inputs and advance the model.
    task automatic cyc(input logic a, input logic [RW-1:0] r, input logic [IDW-1:0] id,
                       input logic rdy, input logic clr, input string tag);
        logic [RW+IDW-1:0] exp_head;
        logic              m_push, m_pop;
        @(negedge clk);
        exp_head = (sb.size() != 0) ? sb[0] : last_out;
        chk({tag, ".count"},     32'(count),            32'(sb.size()));
        chk({tag, ".accept_n"},  32'(accept_n),         32'(sb.size() == DEPTH));
        chk({tag, ".out_valid"}, 32'(out_if.out_valid), 32'(sb.size() != 0));
        chk({tag, ".id_err"},    32'(id_err),           32'(m_err));
        chk({tag, ".out_id"},    32'(out_if.out_id),    32'(exp_head[IDW-1:0]));
        chk({tag, ".out_root"},  32'(out_if.out_root),  32'(exp_head[RW+IDW-1:IDW]));
        if (sb.size() != 0) last_out = sb[0];
        arrive = a; root = r; arrive_id = id; out_if.out_ready = rdy; clr_err = clr;
        m_push = a && (sb.size() != DEPTH);
        m_pop  = rdy && (sb.size() != 0);
        if (m_pop) void'(sb.pop_front());
        if (m_push) begin
            sb.push_back({r, id});
            if (id != m_exp) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_exp = id + 8'd1;
        end else if (clr) begin
            m_err = 1'b0;
        end
    endtask

    initial begin
        int nid;
        out_if.out_ready = 1'b0;

        // 1: reset values, then three pushes with the consumer stalled.
        do_reset();
        cyc(1, 4'd3, 8'd0, 0, 0, "t1.p0");
        cyc(1, 4'd5, 8'd1, 0, 0, "t1.p1");
        cyc(1, 4'd7, 8'd2, 0, 0, "t1.p2");
        cyc(0, 4'd0, 8'd0, 0, 0, "t1.hold");
        cyc(0, 4'd0, 8'd0, 0, 0, "t1.hold2");

        // 2: fill, refused arrive, one pop, then the held result goes in.
        do_reset();
        cyc(0, 4'd0, 8'd0, 1, 0, "t2.empty_rdy");
        for (int i = 0; i < 4; i++) cyc(1, 4'(i + 1), 8'(i), 0, 0, "t2.fill");
        cyc(1, 4'd9, 8'd4, 0, 0, "t2.refuse0");
        cyc(1, 4'd9, 8'd4, 0, 0, "t2.refuse1");
        cyc(1, 4'd9, 8'd4, 1, 0, "t2.pop0");
        cyc(1, 4'd9, 8'd4, 0, 0, "t2.take4");
        cyc(0, 4'd0, 8'd0, 0, 0, "t2.full_again");
        for (int i = 0; i < 5; i++) cyc(0, 4'd0, 8'd0, 1, 0, "t2.drain");
        cyc(0, 4'd0, 8'd0, 0, 0, "t2.emptied");

        // 3: streaming through a full FIFO across pointer wrap, IDs 0..15.
        do_reset();
        nid = 0;
        for (int k = 0; k < 30; k++) begin
            logic a, rdy, pushed;
            a      = (nid < 16);
            rdy    = (k >= 4);
            pushed = a && (sb.size() != DEPTH);
            cyc(a, 4'(nid), 8'(nid), rdy, 0, "t3.stream");
            if (pushed) nid++;
        end
        cyc(0, 4'd0, 8'd0, 0, 0, "t3.end");

        // 4: out-of-sequence ID, clear, and resync.
        do_reset();
        cyc(1, 4'd1, 8'd0, 1, 0, "t4.id0");
        cyc(1, 4'd1, 8'd1, 1, 0, "t4.id1");
        cyc(1, 4'd1, 8'd3, 1, 0, "t4.id3");
        cyc(1, 4'd1, 8'd4, 1, 0, "t4.id4");
        cyc(0, 4'd0, 8'd0, 1, 1, "t4.clr");
        cyc(1, 4'd1, 8'd5, 1, 0, "t4.id5");
        cyc(0, 4'd0, 8'd0, 1, 0, "t4.after5");
        // set beats clear in the same cycle
        cyc(1, 4'd2, 8'd9, 1, 1, "t4.set_vs_clr");
        cyc(0, 4'd0, 8'd0, 1, 0, "t4.setwins");

        // 5: ID wrap 254, 255, 0 after aligning the expected ID.
        do_reset();
        cyc(1, 4'd1, 8'd253, 1, 0, "t5.id253");
        cyc(0, 4'd0, 8'd0, 1, 1, "t5.clr");
        cyc(1, 4'd2, 8'd254, 1, 0, "t5.id254");
        cyc(1, 4'd3, 8'd255, 1, 0, "t5.id255");
        cyc(1, 4'd4, 8'd0, 1, 0, "t5.id0");
        cyc(0, 4'd0, 8'd0, 1, 0, "t5.done");
        cyc(0, 4'd0, 8'd0, 0, 0, "t5.idle");

        // 6: asynchronous reset in the middle of a cycle with data stored.
        do_reset();
        cyc(1, 4'd6, 8'd0, 0, 0, "t6.p0");
        cyc(1, 4'd7, 8'd1, 0, 0, "t6.p1");
        cyc(1, 4'd8, 8'd2, 0, 0, "t6.p2");
        cyc(0, 4'd0, 8'd0, 0, 0, "t6.three");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.count",     32'(count),            32'd0);
        chk("t6.rst.out_valid", 32'(out_if.out_valid), 32'd0);
        chk("t6.rst.accept_n",  32'(accept_n),         32'd0);
        chk("t6.rst.out_id",    32'(out_if.out_id),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 4'd5, 8'd0, 0, 0, "t6.id0");
        cyc(0, 4'd0, 8'd0, 0, 0, "t6.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
